min_dist_search: RTL and testbench
==================================

// Module: min_dist_search
// PURPOSE
//  Hard-decision nearest-codeword stage, directly downstream of the Hamming distance unit.
//  Accepts one received N-bit word and scans a 2^K-entry codeword table, one entry per cycle.
//  Reports the closest codeword's index, value and full-width distance, plus a tie flag.
//  Valid/ready on both sides; the codeword table is written through a simple write port.
// PARAMETERS
//  N   6  codeword width in bits
//  K   3  message width; table depth = 2^K
//  DW  3  distance width, = $clog2(N+1); must hold N without truncation
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      reset: synchronous, active-low
//  cb_we      in   1      table write enable; honoured in IDLE only
//  cb_addr    in   K      table write address
//  cb_data    in   N      table write data
//  in_valid   in   1      received word valid
//  in_ready   out  1      block can accept a word (=1 only in IDLE)
//  in_word    in   N      received word
//  out_valid  out  1      result valid (=1 only in DONE)
//  out_ready  in   1      consumer accepts result
//  out_index  out  K      index of the nearest codeword
//  out_word   out  N      table contents at out_index
//  out_dist   out  DW     Hamming distance, in_word vs out_word
//  out_tie    out  1      another scanned entry had the same minimum distance
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at an edge):
//   - state=IDLE; all table entries=0.
//   - out_*=0; out_valid=0; busy=0; in_ready=1 in the cycle after reset.
//   - Reset mid-SEARCH or mid-DONE aborts; no out_valid is produced.
//  FSM states: IDLE -> SEARCH -> DONE -> IDLE.
//  IDLE:
//   - in_ready=1.
//   - On in_valid&&in_ready: latch in_word, set idx=0, go to SEARCH.
//   - cb_we writes cb_data to cb_addr at the same edge.
//   - A write in the accept cycle is visible to the search that follows.
//  SEARCH (one entry per cycle, at idx):
//   - d = popcount(word ^ table[idx]), DW bits wide.
//   - idx==0: best=d, best_idx=0, tie=0 (unconditional load).
//   - d<best: best=d, best_idx=idx, tie=0.
//   - d==best (idx>0): tie=1; best_idx unchanged, so the lowest index wins.
//   - Exit to DONE when d==0 (early exit) or when idx==2^K-1; otherwise idx++.
//   - Early exit: tie reflects only entries already scanned.
//   - cb_we is ignored; in_ready=0.
//  DONE:
//   - out_valid=1; out_index/out_word/out_dist/out_tie registered and held stable.
//   - On out_valid&&out_ready: out_valid=0 at the next edge, go to IDLE.
//   - A new word can be accepted from the cycle after that; no same-cycle turnaround.
//  Latency (accept edge to the edge asserting out_valid):
//   - Full scan: 2^K clocks (8 by default).
//   - Early exit at index j: j+1 clocks.
//  out_word is captured at the best update, so it is immune to later table writes.
// TESTING (table loaded for a (6,3) code; idx0..7 = 000000 001101 010011 011110 100110 101011 110101 111000)
//  1 in_word=011110 -> early exit; index=3, dist=0, tie=0; latency 4 clocks.
//  2 in_word=011111 -> full scan; index=3, word=011110, dist=1, tie=0; latency 8.
//  3 in_word=111111 -> entries 3/5/6 tie at 2; index=3, dist=2, tie=1.
//  4 Hold out_ready=0 for 5 cycles in DONE -> outputs stable; in_ready=0.
//    in_valid pulses are ignored; after the handshake, in_ready=1 one cycle later.
//  5 Pulse cb_we to idx7 (data 111111) during SEARCH of test 2 -> ignored.
//    A rerun gives the same result as test 2.
//  6 rst_n=0 mid-SEARCH -> no out_valid; table cleared.
//    Then in_word=101010 -> index=0, dist=3, tie=1.

Source files
------------

// File: rtl/min_dist_search.sv
// Nearest-codeword search: scans a 2^K-entry codeword table one entry per cycle and
// reports the index, value and Hamming distance of the closest entry plus a tie flag.
module min_dist_search #(
    parameter int N  = 6,
    parameter int K  = 3,
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cb_we,
    input  logic [K-1:0]  cb_addr,
    input  logic [N-1:0]  cb_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_word,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [K-1:0]  out_index,
    output logic [N-1:0]  out_word,
    output logic [DW-1:0] out_dist,
    output logic          out_tie,
    output logic          busy
);
    localparam int DEPTH = 1 << K;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    function automatic logic [DW-1:0] popcount(input logic [N-1:0] v);
        logic [DW-1:0] c;
        c = {DW{1'b0}};
        for (int i = 0; i < N; i++) begin
            c = c + DW'(v[i]);
        end
        return c;
    endfunction

    state_t        state_q, state_d;
    logic [N-1:0]  table_q [DEPTH];
    logic [N-1:0]  table_d [DEPTH];
    logic [N-1:0]  word_q, word_d;
    logic [K-1:0]  idx_q, idx_d;
    logic [DW-1:0] best_q, best_d;
    logic [K-1:0]  best_idx_q, best_idx_d;
    logic [N-1:0]  best_word_q, best_word_d;
    logic          tie_q, tie_d;
    logic [DW-1:0] dist_s;
    logic          last_s;

    assign dist_s = popcount(word_q ^ table_q[idx_q]);
    assign last_s = (idx_q == K'(DEPTH - 1));

    // Next-state, table write and best-candidate tracking
    always_comb begin
        state_d     = state_q;
        table_d     = table_q;
        word_d      = word_q;
        idx_d       = idx_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        best_word_d = best_word_q;
        tie_d       = tie_q;
        case (state_q)
            S_IDLE: begin
                if (cb_we) begin
                    table_d[cb_addr] = cb_data;
                end else begin
                    table_d = table_q;
                end
                if (in_valid) begin
                    word_d  = in_word;
                    idx_d   = {K{1'b0}};
                    state_d = S_SEARCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEARCH: begin
                // Lowest index wins a tie because only a strictly smaller distance replaces best
                if ((idx_q == {K{1'b0}}) || (dist_s < best_q)) begin
                    best_d      = dist_s;
                    best_idx_d  = idx_q;
                    best_word_d = table_q[idx_q];
                    tie_d       = 1'b0;
                end else if (dist_s == best_q) begin
                    tie_d = 1'b1;
                end else begin
                    tie_d = tie_q;
                end
                if ((dist_s == {DW{1'b0}}) || last_s) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + K'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, table and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= {N{1'b0}};
            end
            word_q      <= {N{1'b0}};
            idx_q       <= {K{1'b0}};
            best_q      <= {DW{1'b0}};
            best_idx_q  <= {K{1'b0}};
            best_word_q <= {N{1'b0}};
            tie_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            table_q     <= table_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            best_word_q <= best_word_d;
            tie_q       <= tie_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_index = best_idx_q;
    assign out_word  = best_word_q;
    assign out_dist  = best_q;
    assign out_tie   = tie_q;

endmodule

// File: tb/tb_min_dist_search.sv
// Directed bench for min_dist_search using a (6,3) codeword table and hand-computed results.
module tb_min_dist_search;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cb_we;
    logic [2:0] cb_addr;
    logic [5:0] cb_data;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_word;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_index;
    logic [5:0] out_word;
    logic [2:0] out_dist;
    logic       out_tie;
    logic       busy;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [5:0] code_tbl [8] = '{6'b000000, 6'b001101, 6'b010011, 6'b011110,
                                 6'b100110, 6'b101011, 6'b110101, 6'b111000};

    min_dist_search #(.N(6), .K(3), .DW(3)) dut (
        .clk(clk), .rst_n(rst_n), .cb_we(cb_we), .cb_addr(cb_addr), .cb_data(cb_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_word(out_word), .out_dist(out_dist), .out_tie(out_tie), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_table();
        for (int i = 0; i < 8; i++) begin
            cb_we   = 1'b1;
            cb_addr = 3'(i);
            cb_data = code_tbl[i];
            tick();
        end
        cb_we = 1'b0;
    endtask

    // Accept a word, wait for the result, check it, optionally stall the consumer, then handshake
    task automatic run_search(input string tag, input logic [5:0] word,
                              input logic [2:0] e_idx, input logic [5:0] e_word,
                              input logic [2:0] e_dist, input logic e_tie, input int e_lat,
                              input int stall, input logic poke_we);
        int lat;
        in_valid = 1'b1;
        in_word  = word;
        tick();
        in_valid = 1'b0;
        check_val({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (poke_we && lat == 1) begin
                cb_we = 1'b1; cb_addr = 3'd7; cb_data = 6'b111111;
            end else begin
                cb_we = 1'b0;
            end
            tick();
            lat++;
        end
        cb_we = 1'b0;
        check_val({tag, "_lat"}, 32'(lat), 32'(e_lat));
        check_val({tag, "_idx"}, 32'(out_index), 32'(e_idx));
        check_val({tag, "_word"}, 32'(out_word), 32'(e_word));
        check_val({tag, "_dist"}, 32'(out_dist), 32'(e_dist));
        check_val({tag, "_tie"}, 32'(out_tie), 32'(e_tie));
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_word  = 6'b000000;
            tick();
            check_val({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check_val({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
            check_val({tag, "_hold_res"}, {18'd0, out_index, out_word, out_dist, out_tie},
                      {18'd0, e_idx, e_word, e_dist, e_tie});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        check_val({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
        check_val({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cb_we = 1'b0; cb_addr = 3'd0; cb_data = 6'd0;
        in_valid = 1'b0; in_word = 6'd0; out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_val("rst_ready", 32'(in_ready), 32'd1);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_outs", {22'd0, out_index, out_word, out_tie}, 32'd0);
        check_val("rst_dist", 32'(out_dist), 32'd0);

        load_table();
        run_search("t1", 6'b011110, 3'd3, 6'b011110, 3'd0, 1'b0, 4, 0, 1'b0);
        run_search("t2", 6'b011111, 3'd3, 6'b011110, 3'd1, 1'b0, 8, 0, 1'b0);
        run_search("t3", 6'b111111, 3'd3, 6'b011110, 3'd2, 1'b1, 8, 5, 1'b0);
        // The stalled in_valid pulses must not have started a search
        tick();
        check_val("t4_no_start", 32'(busy), 32'd0);
        run_search("t5a", 6'b011111, 3'd3, 6'b011110, 3'd1, 1'b0, 8, 0, 1'b1);
        run_search("t5b", 6'b011111, 3'd3, 6'b011110, 3'd1, 1'b0, 8, 0, 1'b0);

        in_valid = 1'b1;
        in_word  = 6'b111111;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check_val("t6_no_valid", 32'(out_valid), 32'd0);
            tick();
        end
        check_val("t6_ready", 32'(in_ready), 32'd1);
        run_search("t6", 6'b101010, 3'd0, 6'b000000, 3'd3, 1'b1, 8, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
